// File: rtl/user_gpio_pkg.sv
`default_nettype none
// ============================================================================
// Package     : user_gpio_pkg
// Description : Register offsets and helpers shared by the user GPIO bank.
// Revision    : 1.0 - initial release
// ============================================================================
package user_gpio_pkg;

    localparam int NPINS_MAX = 64;

    localparam logic [7:0] REG_OUT_LO = 8'h00;
    localparam logic [7:0] REG_OUT_HI = 8'h04;
    localparam logic [7:0] REG_OE_LO  = 8'h08;
    localparam logic [7:0] REG_OE_HI  = 8'h0C;
    localparam logic [7:0] REG_IN_LO  = 8'h10;
    localparam logic [7:0] REG_IN_HI  = 8'h14;
    localparam logic [7:0] REG_IEN_LO = 8'h18;
    localparam logic [7:0] REG_IEN_HI = 8'h1C;
    localparam logic [7:0] REG_IST_LO = 8'h20;
    localparam logic [7:0] REG_IST_HI = 8'h24;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        return (old_v & ~lane_mask(sel)) | (new_v & lane_mask(sel));
    endfunction

endpackage
`default_nettype wire

// File: rtl/user_gpio_sync.sv
`default_nettype none
// ============================================================================
// Module      : user_gpio_sync
// Description : Two-flop pad synchronizer with a history stage for rise detect.
// Revision    : 1.0 - initial release
// ============================================================================
module user_gpio_sync #(
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    always_comb begin
        s1_d   = i_d;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign o_sync = s2_q;
    assign o_rise = s2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/user_gpio_wb_bank.sv
`default_nettype none
// ============================================================================
// Module      : user_gpio_wb_bank
// Description : Wishbone GPIO bank driving user pads with rise-edge interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
module user_gpio_wb_bank
    import user_gpio_pkg::*;
#(
    parameter int          NPINS     = 38,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic [31:0]      wbs_dat_o,
    output logic             wbs_ack_o,
    input  logic [NPINS-1:0] io_in,
    output logic [NPINS-1:0] io_out,
    output logic [NPINS-1:0] io_oeb,
    output logic             user_irq
);

    // Registers are held at full 64-bit width; bits above NPINS are forced to 0.
    localparam logic [63:0] PIN_MASK = (NPINS >= NPINS_MAX) ? {64{1'b1}}
                                                            : ((64'd1 << NPINS) - 64'd1);

    logic [63:0] out_q, out_d;
    logic [63:0] oe_q, oe_d;
    logic [63:0] ien_q, ien_d;
    logic [63:0] ist_q, ist_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        irq_q, irq_d;

    logic [NPINS-1:0] w_sync, w_rise;
    logic [63:0]      w_in, w_rise64, w_clr;
    logic [31:0]      w_rdata;
    logic [7:0]       w_off;
    logic             w_hit, w_access, w_wr;
    logic [1:0]       unused_bits;

    user_gpio_sync #(
        .WIDTH (NPINS)
    ) u_sync (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .i_d    (io_in),
        .o_sync (w_sync),
        .o_rise (w_rise)
    );

    assign unused_bits = wbs_adr_i[1:0];
    assign w_off       = {wbs_adr_i[7:2], 2'b00};
    assign w_hit       = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_access    = wbs_cyc_i & wbs_stb_i & w_hit & ~ack_q;
    assign w_wr        = w_access & wbs_we_i;

    always_comb begin
        w_in     = '0;
        w_rise64 = '0;
        w_in[NPINS-1:0]     = w_sync;
        w_rise64[NPINS-1:0] = w_rise;
    end

    always_comb begin
        out_d = out_q;
        oe_d  = oe_q;
        ien_d = ien_q;
        w_clr = '0;
        if (w_wr) begin
            case (w_off)
                REG_OUT_LO: out_d[31:0]  = byte_merge(out_q[31:0],  wbs_dat_i, wbs_sel_i);
                REG_OUT_HI: out_d[63:32] = byte_merge(out_q[63:32], wbs_dat_i, wbs_sel_i);
                REG_OE_LO:  oe_d[31:0]   = byte_merge(oe_q[31:0],   wbs_dat_i, wbs_sel_i);
                REG_OE_HI:  oe_d[63:32]  = byte_merge(oe_q[63:32],  wbs_dat_i, wbs_sel_i);
                REG_IEN_LO: ien_d[31:0]  = byte_merge(ien_q[31:0],  wbs_dat_i, wbs_sel_i);
                REG_IEN_HI: ien_d[63:32] = byte_merge(ien_q[63:32], wbs_dat_i, wbs_sel_i);
                REG_IST_LO: w_clr[31:0]  = wbs_dat_i & lane_mask(wbs_sel_i);
                REG_IST_HI: w_clr[63:32] = wbs_dat_i & lane_mask(wbs_sel_i);
                default:    ;
            endcase
        end
        out_d = out_d & PIN_MASK;
        oe_d  = oe_d & PIN_MASK;
        ien_d = ien_d & PIN_MASK;
        // A rise in the same cycle as its W1C keeps the bit set.
        ist_d = ((ist_q & ~w_clr) | w_rise64) & PIN_MASK;
        irq_d = |(ist_d & ien_d);
    end

    always_comb begin
        case (w_off)
            REG_OUT_LO: w_rdata = out_q[31:0];
            REG_OUT_HI: w_rdata = out_q[63:32];
            REG_OE_LO:  w_rdata = oe_q[31:0];
            REG_OE_HI:  w_rdata = oe_q[63:32];
            REG_IN_LO:  w_rdata = w_in[31:0];
            REG_IN_HI:  w_rdata = w_in[63:32];
            REG_IEN_LO: w_rdata = ien_q[31:0];
            REG_IEN_HI: w_rdata = ien_q[63:32];
            REG_IST_LO: w_rdata = ist_q[31:0];
            REG_IST_HI: w_rdata = ist_q[63:32];
            default:    w_rdata = '0;
        endcase
        ack_d = w_access;
        dat_d = (w_access && !wbs_we_i) ? w_rdata : '0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            out_q <= '0;
            oe_q  <= '0;
            ien_q <= '0;
            ist_q <= '0;
            ack_q <= 1'b0;
            dat_q <= '0;
            irq_q <= 1'b0;
        end else begin
            out_q <= out_d;
            oe_q  <= oe_d;
            ien_q <= ien_d;
            ist_q <= ist_d;
            ack_q <= ack_d;
            dat_q <= dat_d;
            irq_q <= irq_d;
        end
    end

    assign io_out    = out_q[NPINS-1:0];
    assign io_oeb    = ~oe_q[NPINS-1:0];
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign user_irq  = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_user_gpio_wb_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_user_gpio_wb_bank
// Description : Scoreboard bench for the Wishbone GPIO bank (NPINS=38).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_user_gpio_wb_bank;

    localparam int NPINS = 38;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic             clk;
    logic             rst_n;
    logic             cyc, stb, we;
    logic [3:0]       sel;
    logic [31:0]      adr, wdat;
    logic [31:0]      rdat;
    logic             ack;
    logic [NPINS-1:0] io_in, io_out, io_oeb;
    logic             irq;

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
    } sb_entry_t;

    sb_entry_t sb[$];
    int checks = 0;
    int errors = 0;

    user_gpio_wb_bank #(
        .NPINS     (NPINS),
        .BASE_ADDR (BASE)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_dat_o (rdat),
        .wbs_ack_o (ack),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .user_irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every ack consumes one scoreboard entry; reads compare data.
    initial begin
        sb_entry_t e;
        forever begin
            @(negedge clk);
            if (ack === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack=1 expected no transaction");
                end else begin
                    e = sb.pop_front();
                    if (e.is_rd) begin
                        checks++;
                        if (rdat !== e.data) begin
                            errors++;
                            $display("FAIL read_data: got 0x%08h expected 0x%08h", rdat, e.data);
                        end
                    end
                end
            end
        end
    end

    // For reads, d is the expected data; for writes, the write data.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic expect_ack);
        int  n;
        bit  got;
        if (expect_ack) sb.push_back('{is_rd: !w, data: d});
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s;
        wdat = w ? d : 32'h0;
        n = 0; got = 0;
        while (n < 10 && !got) begin
            @(posedge clk); #1;
            n++;
            if (ack) got = 1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (expect_ack) begin
            chk("ack_latency", 64'(n), 64'd1);
            if (!got) void'(sb.pop_back());
        end else begin
            chk("no_ack_on_miss", 64'(got), 64'd0);
        end
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
        xfer(1'b1, BASE | 32'(off), d, s, 1'b1);
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp);
        xfer(1'b0, BASE | 32'(off), exp, 4'hF, 1'b1);
    endtask

    task automatic settle;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = 32'h0; wdat = 32'h0; io_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        chk("reset_out", 64'(io_out), 64'h0);
        chk("reset_irq", 64'(irq), 64'h0);
        chk("reset_ack", 64'(ack), 64'h0);
        rst_n = 1'b1;

        wr(8'h08, 32'h0000_00FF, 4'b0001);
        wr(8'h00, 32'h0000_00A5, 4'b0001);
        settle();
        chk("oe_lo_pins", 64'(io_oeb), 64'h3F_FFFF_FF00);
        chk("out_lo_pins", 64'(io_out), 64'hA5);

        wr(8'h00, 32'hFFFF_FFFF, 4'b0010);
        settle();
        chk("out_lane1_pins", 64'(io_out), 64'hFFA5);
        rd(8'h00, 32'h0000_FFA5);

        // Upper half only holds pins 37:32
        rd(8'h0C, 32'h0);
        wr(8'h0C, 32'hFFFF_FFFF, 4'hF);
        wr(8'h04, 32'hFFFF_FFFF, 4'hF);
        rd(8'h0C, 32'h0000_003F);
        rd(8'h04, 32'h0000_003F);
        settle();
        chk("oe_hi_pins", 64'(io_oeb), 64'h00_FFFF_FF00);
        chk("out_hi_pins", 64'(io_out), 64'h3F_0000_FFA5);

        io_in[33] = 1'b1;
        repeat (3) @(posedge clk);
        rd(8'h14, 32'h0000_0002);
        rd(8'h10, 32'h0);
        rd(8'h24, 32'h0000_0002);
        rd(8'h20, 32'h0);
        chk("irq_masked", 64'(irq), 64'h0);
        wr(8'h1C, 32'h0000_0002, 4'hF);
        settle();
        chk("irq_enabled", 64'(irq), 64'h1);

        // Re-arm pin 33 so its next rise lands in the W1C access cycle.
        io_in[33] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        io_in[33] = 1'b1;
        @(posedge clk);
        wr(8'h24, 32'h0000_0002, 4'hF);
        settle();
        chk("irq_set_wins", 64'(irq), 64'h1);
        rd(8'h24, 32'h0000_0002);

        wr(8'h24, 32'h0000_0002, 4'b0010);
        rd(8'h24, 32'h0000_0002);
        wr(8'h24, 32'h0000_0002, 4'hF);
        settle();
        chk("irq_cleared", 64'(irq), 64'h0);
        rd(8'h24, 32'h0);

        rd(8'h40, 32'h0);
        xfer(1'b0, 32'h3000_1000, 32'h0, 4'hF, 1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
